// File: rtl/rgmii_rx_decoder_pkg.sv
// Shared encodings for the RGMII receive decoder: line speeds, framing
// bytes, control codes and the framer / nibble-phase state types.
package rgmii_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] FALSE_CARRIER = 8'h0E;
  localparam logic [7:0] CARRIER_EXT   = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_ERRWAIT
  } rx_state_e;

  typedef enum logic {
    PH_LOW,
    PH_HIGH
  } nib_phase_e;

  // 10 and the reserved 11 encoding both run the byte-wide 1000M path.
  function automatic logic is_gig(input logic [1:0] spd);
    return spd[1];
  endfunction

endpackage

// File: rtl/rgmii_rx_decoder_if.sv
// GMII-side receive stream from the decoder to the MAC receive path.
interface rgmii_rx_decoder_if;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] gmii_rxd;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_frame_bad;

  modport master (
    output gmii_rx_dv, gmii_rx_er, gmii_rxd, rx_sof, rx_eof, rx_frame_bad
  );

  modport slave (
    input gmii_rx_dv, gmii_rx_er, gmii_rxd, rx_sof, rx_eof, rx_frame_bad
  );
endinterface

// File: rtl/rgmii_rx_decoder_nibble_pack.sv
// Byte assembly for the receive path. In 1000M the two DDR halves form a
// byte every dv cycle; in 10/100 rising-edge nibbles are paired low-first
// and the error flag is merged across the pair.
module rgmii_nibble_pack
  import rgmii_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       gig_i,
  input  logic       dv_i,
  input  logic       er_i,
  input  logic [3:0] rxd_p_i,
  input  logic [3:0] rxd_n_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_o,
  output logic       byte_er_o,
  output logic       dangling_o
);

  nib_phase_e phase_q, phase_d;
  logic [3:0] lo_q;
  logic       lo_er_q;

  // Phase toggles per dv cycle in nibble mode; any gap realigns to LOW.
  always_comb begin
    phase_d = phase_q;
    if (!dv_i || gig_i)
      phase_d = PH_LOW;
    else
      phase_d = (phase_q == PH_LOW) ? PH_HIGH : PH_LOW;
  end

  // Phase register and held low nibble with its error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= PH_LOW;
      lo_q    <= 4'h0;
      lo_er_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (dv_i && !gig_i && phase_q == PH_LOW) begin
        lo_q    <= rxd_p_i;
        lo_er_q <= er_i;
      end
    end
  end

  // Byte output; a held low nibble at dv fall is reported, never emitted.
  always_comb begin
    byte_vld_o = 1'b0;
    byte_o     = {rxd_n_i, rxd_p_i};
    byte_er_o  = er_i;
    if (gig_i) begin
      byte_vld_o = dv_i;
    end else begin
      byte_vld_o = dv_i && (phase_q == PH_HIGH);
      byte_o     = {rxd_p_i, lo_q};
      byte_er_o  = er_i | lo_er_q;
    end
    dangling_o = !dv_i && (phase_q == PH_HIGH);
  end

endmodule

// File: rtl/rgmii_rx_decoder.sv
// RGMII receive decoder: input staging, framing FSM, GMII output stage,
// in-band link status decode and saturating good/bad frame counters.
module rgmii_rx_decoder
  import rgmii_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int STATUS_EN     = 1,
  parameter int STATUS_STABLE = 2
) (
  input  logic             gmii_rx_clk,
  input  logic             rst,
  input  logic [3:0]       ddr_rxd_p,
  input  logic [3:0]       ddr_rxd_n,
  input  logic             ddr_ctl_p,
  input  logic             ddr_ctl_n,
  input  logic [1:0]       speed_mode,
  rgmii_rx_decoder_if.master gmii,
  output logic             link_up,
  output logic [1:0]       link_speed,
  output logic             link_duplex,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  logic [3:0] rxd_p_q, rxd_n_q;
  logic       ctl_p_q, ctl_n_q;
  logic       dv, er, dv_prev_q, fall, gig_q;

  // Stage 1: register every DDR input.
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      rxd_p_q <= 4'h0;
      rxd_n_q <= 4'h0;
      ctl_p_q <= 1'b0;
      ctl_n_q <= 1'b0;
    end else begin
      rxd_p_q <= ddr_rxd_p;
      rxd_n_q <= ddr_rxd_n;
      ctl_p_q <= ddr_ctl_p;
      ctl_n_q <= ddr_ctl_n;
    end
  end

  assign dv   = ctl_p_q;
  assign er   = ctl_p_q ^ ctl_n_q;
  assign fall = dv_prev_q & ~dv;

  logic       byte_vld, byte_er, dangling;
  logic [7:0] byte_val;

  rgmii_nibble_pack u_pack (
    .clk_i      (gmii_rx_clk),
    .rst_i      (rst),
    .gig_i      (gig_q),
    .dv_i       (dv),
    .er_i       (er),
    .rxd_p_i    (rxd_p_q),
    .rxd_n_i    (rxd_n_q),
    .byte_vld_o (byte_vld),
    .byte_o     (byte_val),
    .byte_er_o  (byte_er),
    .dangling_o (dangling)
  );

  rx_state_e state_q, state_d;
  logic      sof_pend_q, sof_pend_d;
  logic      bad_acc_q, bad_acc_d;
  logic      frame_bad;

  // Framer next state. Only dv matters here, so dv=0 control codes
  // (false carrier, carrier extend) never move the FSM.
  always_comb begin
    state_d    = state_q;
    sof_pend_d = sof_pend_q;
    bad_acc_d  = bad_acc_q | (byte_vld & byte_er);
    if (fall) begin
      state_d    = ST_IDLE;
      sof_pend_d = 1'b0;
      bad_acc_d  = 1'b0;
    end else if (byte_vld) begin
      case (state_q)
        ST_IDLE: state_d = ST_PREAMBLE;
        ST_PREAMBLE: begin
          if (byte_val == SFD_BYTE) begin
            state_d    = ST_DATA;
            sof_pend_d = 1'b1;
          end else if (byte_val != PREAMBLE_BYTE) begin
            state_d   = ST_ERRWAIT;
            bad_acc_d = 1'b1;
          end
        end
        ST_DATA: sof_pend_d = 1'b0;
        default: ;
      endcase
    end
    frame_bad = bad_acc_q | (state_q != ST_DATA) | dangling;
  end

  logic       rx_dv_q, rx_er_q, sof_q, eof_q, bad_q;
  logic [7:0] rxd_q;

  // Framer state, speed latch (only while idle) and GMII output stage.
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sof_pend_q <= 1'b0;
      bad_acc_q  <= 1'b0;
      dv_prev_q  <= 1'b0;
      gig_q      <= 1'b0;
      rx_dv_q    <= 1'b0;
      rx_er_q    <= 1'b0;
      rxd_q      <= 8'h00;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sof_pend_q <= sof_pend_d;
      bad_acc_q  <= bad_acc_d;
      dv_prev_q  <= dv;
      if (state_q == ST_IDLE && !dv) gig_q <= is_gig(speed_mode);
      rx_dv_q    <= byte_vld;
      rx_er_q    <= byte_vld & byte_er;
      if (byte_vld) rxd_q <= byte_val;
      sof_q      <= byte_vld & (state_q == ST_DATA) & sof_pend_q;
      eof_q      <= fall;
      bad_q      <= fall & frame_bad;
    end
  end

  assign gmii.gmii_rx_dv   = rx_dv_q;
  assign gmii.gmii_rx_er   = rx_er_q;
  assign gmii.gmii_rxd     = rxd_q;
  assign gmii.rx_sof       = sof_q;
  assign gmii.rx_eof       = eof_q;
  assign gmii.rx_frame_bad = bad_q;

  // Saturating frame counters, advanced the cycle after rx_eof.
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (eof_q) begin
      if (!bad_q && !(&good_cnt)) good_cnt <= good_cnt + CNT_W'(1);
      if (bad_q && !(&bad_cnt))   bad_cnt  <= bad_cnt + CNT_W'(1);
    end
  end

  generate
    if (STATUS_EN != 0) begin : g_status
      localparam logic [3:0] STABLE = 4'(STATUS_STABLE);
      logic [3:0] st_cnt_q, st_cnt_d, st_last_q, st_last_d;
      logic       st_upd;

      // Stability tracking of idle in-band samples; frame activity restarts it.
      always_comb begin
        st_cnt_d  = st_cnt_q;
        st_last_d = st_last_q;
        if (dv || er) begin
          st_cnt_d = 4'd0;
        end else if (st_cnt_q != 4'd0 && rxd_p_q == st_last_q) begin
          if (st_cnt_q != STABLE) st_cnt_d = st_cnt_q + 4'd1;
        end else begin
          st_cnt_d  = 4'd1;
          st_last_d = rxd_p_q;
        end
        st_upd = !dv && !er && (st_cnt_d == STABLE);
      end

      // Stability state and link-status outputs.
      always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
          st_cnt_q    <= 4'd0;
          st_last_q   <= 4'h0;
          link_up     <= 1'b0;
          link_speed  <= 2'b00;
          link_duplex <= 1'b0;
        end else begin
          st_cnt_q  <= st_cnt_d;
          st_last_q <= st_last_d;
          if (st_upd) begin
            link_up     <= rxd_p_q[0];
            link_speed  <= rxd_p_q[2:1];
            link_duplex <= rxd_p_q[3];
          end
        end
      end
    end else begin : g_no_status
      assign link_up     = 1'b0;
      assign link_speed  = 2'b00;
      assign link_duplex = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Directed bench for rgmii_rx_decoder: 1000M/100M/10M framing, ER and
// dangling-nibble bad frames, in-band status, saturation and reset abort.
module tb_rgmii_rx_decoder;
  import rgmii_pkg::*;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    rxd_p, rxd_n;
  logic          ctl_p, ctl_n;
  logic [1:0]    speed_mode;
  logic          link_up, link_duplex;
  logic [1:0]    link_speed;
  logic [CW-1:0] good_cnt, bad_cnt;

  rgmii_rx_decoder_if gmii();

  rgmii_rx_decoder #(.CNT_W(CW), .STATUS_EN(1), .STATUS_STABLE(2)) dut (
    .gmii_rx_clk (clk),
    .rst         (rst),
    .ddr_rxd_p   (rxd_p),
    .ddr_rxd_n   (rxd_n),
    .ddr_ctl_p   (ctl_p),
    .ddr_ctl_n   (ctl_n),
    .speed_mode  (speed_mode),
    .gmii        (gmii),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .link_duplex (link_duplex),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [7:0] q_byte[$];
  bit         q_er[$], q_sof[$], q_bad[$];
  int         q_cyc[$], q_eofcyc[$], q_good_at_eof[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (gmii.gmii_rx_dv) begin
        q_byte.push_back(gmii.gmii_rxd);
        q_er.push_back(gmii.gmii_rx_er);
        q_sof.push_back(gmii.rx_sof);
        q_cyc.push_back(cyc);
      end
      if (gmii.rx_eof) begin
        q_bad.push_back(gmii.rx_frame_bad);
        q_eofcyc.push_back(cyc);
        q_good_at_eof.push_back(int'(good_cnt));
      end
    end
  end

  task automatic clrq();
    q_byte.delete(); q_er.delete(); q_sof.delete(); q_cyc.delete();
    q_bad.delete(); q_eofcyc.delete(); q_good_at_eof.delete(); exp_q.delete();
  endtask

  task automatic put(input logic [3:0] p, input logic [3:0] n, input logic cp, input logic cn);
    rxd_p = p; rxd_n = n; ctl_p = cp; ctl_n = cn;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    repeat (k) put(4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic gig_byte(input logic [7:0] b, input bit err);
    exp_q.push_back(b);
    put(b[3:0], b[7:4], 1'b1, !err);
  endtask

  task automatic nib_byte(input logic [7:0] b);
    exp_q.push_back(b);
    put(b[3:0], 4'h0, 1'b1, 1'b1);
    put(b[7:4], 4'h0, 1'b1, 1'b1);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_len"}, q_byte.size(), exp_q.size());
    for (int i = 0; i < q_byte.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), q_byte[i], exp_q[i]);
  endtask

  task automatic chk_sof(input string tag, input int idx);
    int cnt, at;
    cnt = 0; at = -1;
    for (int i = 0; i < q_sof.size(); i++)
      if (q_sof[i]) begin cnt++; at = i; end
    chk({tag, "_sof_cnt"}, cnt, 1);
    chk({tag, "_sof_idx"}, at, idx);
  endtask

  task automatic chk_eof(input string tag, input bit bad);
    chk({tag, "_eof_cnt"}, q_bad.size(), 1);
    if (q_bad.size() > 0) chk({tag, "_eof_bad"}, q_bad[0], bad);
  endtask

  initial begin
    int t0, n_eof, n_er;

    rst = 1'b1; speed_mode = SPD_1000;
    rxd_p = 4'h0; rxd_n = 4'h0; ctl_p = 1'b0; ctl_n = 1'b0;
    idle(3);
    chk("rst_dv",   gmii.gmii_rx_dv, 0);
    chk("rst_rxd",  gmii.gmii_rxd, 0);
    chk("rst_eof",  gmii.rx_eof, 0);
    chk("rst_good", good_cnt, 0);
    chk("rst_link", link_up, 0);
    rst = 1'b0;
    idle(4);

    // 1000M good frame
    clrq();
    t0 = cyc;
    for (int i = 0; i < 7; i++) gig_byte(PREAMBLE_BYTE, 0);
    gig_byte(SFD_BYTE, 0);
    for (int i = 1; i <= 64; i++) gig_byte(8'(i), 0);
    idle(4);
    chk_stream("g1");
    if (q_cyc.size() > 0) begin
      chk("g1_lat", q_cyc[0] - t0, 2);
      chk("g1_eof_cyc", q_eofcyc.size() > 0 ? q_eofcyc[0] : -1, q_cyc[q_cyc.size()-1] + 1);
    end
    chk_sof("g1", 8);
    chk_eof("g1", 0);
    if (q_good_at_eof.size() > 0) chk("g1_good_at_eof", q_good_at_eof[0], 0);
    chk("g1_good", good_cnt, 1);
    chk("g1_bad", bad_cnt, 0);

    // 100M good frame
    speed_mode = SPD_100;
    idle(4);
    clrq();
    t0 = cyc;
    for (int i = 0; i < 7; i++) nib_byte(PREAMBLE_BYTE);
    nib_byte(SFD_BYTE);
    nib_byte(8'h01);
    nib_byte(8'h02);
    idle(4);
    chk_stream("m100");
    if (q_cyc.size() > 0) chk("m100_lat", q_cyc[0] - (t0 + 1), 2);
    for (int i = 1; i < q_cyc.size(); i++)
      chk($sformatf("m100_gap%0d", i), q_cyc[i] - q_cyc[i-1], 2);
    chk_sof("m100", 8);
    chk_eof("m100", 0);
    chk("m100_good", good_cnt, 2);

    // 10M frame ending with a dangling nibble
    speed_mode = SPD_10;
    idle(4);
    clrq();
    for (int i = 0; i < 7; i++) nib_byte(PREAMBLE_BYTE);
    nib_byte(SFD_BYTE);
    nib_byte(8'hAB);
    put(4'h3, 4'h0, 1'b1, 1'b1);
    idle(4);
    chk_stream("m10");
    chk_eof("m10", 1);
    chk("m10_bad", bad_cnt, 1);
    chk("m10_good", good_cnt, 2);

    // 1000M frame with RX_ER on byte 20
    speed_mode = SPD_1000;
    idle(4);
    clrq();
    for (int i = 0; i < 7; i++) gig_byte(PREAMBLE_BYTE, 0);
    gig_byte(SFD_BYTE, 0);
    for (int i = 8; i < 40; i++) gig_byte(8'(i - 7), i == 20);
    idle(4);
    chk_stream("er");
    n_er = 0;
    for (int i = 0; i < q_er.size(); i++) if (q_er[i]) n_er++;
    chk("er_cnt", n_er, 1);
    if (q_er.size() > 20) chk("er_b20", q_er[20], 1);
    chk_eof("er", 1);
    chk("er_bad", bad_cnt, 2);
    chk("er_good", good_cnt, 2);

    // In-band status: 4'b1101 -> link up, speed 10, full duplex
    clrq();
    chk("st_pre", link_up, 0);
    put(4'hD, 4'h0, 1'b0, 1'b0);
    put(4'hD, 4'h0, 1'b0, 1'b0);
    chk("st_one", link_up, 0);
    put(4'hD, 4'h0, 1'b0, 1'b0);
    chk("st_up", link_up, 1);
    chk("st_spd", link_speed, 2);
    chk("st_dup", link_duplex, 1);
    put(4'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st_glitch%0d", i), {link_up, link_speed, link_duplex}, 4'b1101);
      put(4'hD, 4'h0, 1'b0, 1'b0);
    end
    // Out-of-frame control codes: no frame, no counter change
    put(FALSE_CARRIER[3:0], FALSE_CARRIER[7:4], 1'b0, 1'b1);
    put(CARRIER_EXT[3:0], CARRIER_EXT[7:4], 1'b0, 1'b1);
    put(4'hD, 4'h0, 1'b0, 1'b0);
    put(4'hD, 4'h0, 1'b0, 1'b0);
    idle(1);
    chk("cc_eof", q_bad.size(), 0);
    chk("cc_dv", q_byte.size(), 0);
    chk("cc_cnt", {good_cnt, bad_cnt}, {2'd2, 2'd2});

    // Saturation of the good counter
    for (int f = 0; f < 2; f++) begin
      clrq();
      idle(2);
      gig_byte(PREAMBLE_BYTE, 0);
      gig_byte(SFD_BYTE, 0);
      gig_byte(8'h01, 0);
      idle(4);
      chk_eof($sformatf("sat%0d", f), 0);
      chk($sformatf("sat%0d_good", f), good_cnt, 3);
    end

    // Reset asserted mid-frame
    clrq();
    gig_byte(PREAMBLE_BYTE, 0);
    gig_byte(PREAMBLE_BYTE, 0);
    gig_byte(PREAMBLE_BYTE, 0);
    chk("ra_dv_pre", gmii.gmii_rx_dv, 1);
    #2 rst = 1'b1;
    #1;
    chk("ra_dv", gmii.gmii_rx_dv, 0);
    chk("ra_rxd", gmii.gmii_rxd, 0);
    chk("ra_cnt", {good_cnt, bad_cnt}, 0);
    chk("ra_link", {link_up, link_speed, link_duplex}, 0);
    idle(2);
    rst = 1'b0;
    n_eof = q_bad.size();
    idle(6);
    chk("ra_no_eof", q_bad.size(), n_eof);
    chk("ra_cnt_post", {good_cnt, bad_cnt}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
